// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator: stage 1 subtracts and captures flags, stage 2 decodes the
// selected compare into s[0]. Valid/ready handshake on both sides, one beat buffered per stage.
module cmp_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] s,
  output logic [2:0]       flags
);

  typedef enum logic [2:0] {
    ModeNeq = 3'b000,
    ModeEq  = 3'b001,
    ModeLt  = 3'b010,
    ModeLtu = 3'b011,
    ModeGez = 3'b100,
    ModeLtz = 3'b101,
    ModeLez = 3'b110,
    ModeGtz = 3'b111
  } mode_e;

  logic             v1_q, v2_q;
  logic             zero1_q, neg1_q, ovf1_q, borrow1_q;
  mode_e            mode1_q;
  logic [OUT_W-1:0] s_q, s_d;
  logic [2:0]       flags_q;

  logic             accept, advance;
  logic [WIDTH-1:0] b_eff, diff;
  logic             ovf_d, borrow_d;
  logic             res;

  assign in_ready  = !v1_q || !v2_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign advance   = v1_q && (!v2_q || out_ready);
  assign out_valid = v2_q;
  assign s         = s_q;
  assign flags     = flags_q;

  // Zero-compare modes (mode[2] set) subtract zero so b is ignored.
  always_comb begin
    b_eff    = mode[2] ? '0 : b;
    diff     = a - b_eff;
    ovf_d    = (a[WIDTH-1] != b_eff[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    borrow_d = a < b_eff;
  end

  always_comb begin
    res = 1'b0;
    unique case (mode1_q)
      ModeEq:  res = zero1_q;
      ModeNeq: res = !zero1_q;
      ModeLt:  res = neg1_q ^ ovf1_q;
      ModeLtu: res = borrow1_q;
      ModeLez: res = neg1_q | zero1_q;
      ModeLtz: res = neg1_q;
      ModeGtz: res = !neg1_q && !zero1_q;
      ModeGez: res = !neg1_q;
    endcase
    s_d    = '0;
    s_d[0] = res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      zero1_q   <= 1'b0;
      neg1_q    <= 1'b0;
      ovf1_q    <= 1'b0;
      borrow1_q <= 1'b0;
      mode1_q   <= ModeNeq;
    end else begin
      // A capture while stage 1 is full implies it also advances this cycle.
      v1_q <= accept || (v1_q && !advance);
      if (accept) begin
        zero1_q   <= (diff == '0);
        neg1_q    <= diff[WIDTH-1];
        ovf1_q    <= ovf_d;
        borrow1_q <= borrow_d;
        mode1_q   <= mode_e'(mode);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      s_q     <= '0;
      flags_q <= '0;
    end else begin
      v2_q <= advance || (v2_q && !out_ready);
      if (advance) begin
        s_q     <= s_d;
        flags_q <= {ovf1_q, neg1_q, zero1_q};
      end
    end
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard bench for cmp_pipe: a 32-bit instance for directed and random traffic and an
// 8-bit, OUT_W=1 instance for the mode/corner sweep, both against an arithmetic model.
module tb_cmp_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv0, ir0, ov0, or0;
  logic [31:0] a0, b0, s0;
  logic [2:0]  m0, f0;
  logic        iv1, ir1, ov1, or1;
  logic [7:0]  a1, b1;
  logic [0:0]  s1;
  logic [2:0]  m1, f1;

  cmp_pipe #(.WIDTH(32), .OUT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .mode(m0),
    .out_valid(ov0), .out_ready(or0), .s(s0), .flags(f0)
  );

  cmp_pipe #(.WIDTH(8), .OUT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .mode(m1),
    .out_valid(ov1), .out_ready(or1), .s(s1), .flags(f1)
  );

  typedef struct {
    logic       s;
    logic [2:0] f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;

  logic rand_rdy0 = 1'b0, rand_rdy1 = 1'b0;
  logic want0 = 1'b0, want1 = 1'b1;
  logic rnd0 = 1'b0, rnd1 = 1'b0;
  assign or0 = rand_rdy0 ? rnd0 : want0;
  assign or1 = rand_rdy1 ? rnd1 : want1;

  always begin
    @(posedge clk);
    #1;
    rnd0 = ($urandom_range(0, 3) != 0);
    rnd1 = ($urandom_range(0, 1) != 0);
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Returns {ovf, neg, zero, result} from true signed/unsigned values of the operands.
  function automatic logic [3:0] model(input int w, input logic [2:0] m,
                                       input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, ua, ub, d;
    longint      sa, sb, df, maxv, minv;
    logic        r, ovf, neg, zero;
    mask = (64'd1 << w) - 64'd1;
    ua   = a & mask;
    ub   = m[2] ? 64'd0 : (b & mask);
    sa   = $signed(ua << (64 - w)) >>> (64 - w);
    sb   = $signed(ub << (64 - w)) >>> (64 - w);
    df   = sa - sb;
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    ovf  = (df > maxv) || (df < minv);
    d    = (ua - ub) & mask;
    zero = (d == 64'd0);
    neg  = d[w-1];
    case (m)
      3'b001:  r = (ua == ub);
      3'b000:  r = (ua != ub);
      3'b010:  r = (sa < sb);
      3'b011:  r = (ua < ub);
      3'b110:  r = (sa <= 0);
      3'b101:  r = (sa < 0);
      3'b111:  r = (sa > 0);
      default: r = (sa >= 0);
    endcase
    return {ovf, neg, zero, r};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid dropped.
  task automatic send(input int sel, input logic [2:0] m, input logic [63:0] a,
                      input logic [63:0] b);
    logic [3:0] e;
    bit         got;
    int         n;
    got = 0;
    n   = 0;
    if (sel == 0) begin
      iv0 = 1'b1; a0 = a[31:0]; b0 = b[31:0]; m0 = m;
      e = model(32, m, a, b);
    end else begin
      iv1 = 1'b1; a1 = a[7:0]; b1 = b[7:0]; m1 = m;
      e = model(8, m, a, b);
    end
    do begin
      @(negedge clk);
      got = (sel == 0) ? ir0 : ir1;
      if (got) begin
        if (sel == 0) q0.push_back('{s: e[0], f: e[3:1]});
        else          q1.push_back('{s: e[0], f: e[3:1]});
      end
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 300);
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got no accept expected accept within 300 cycles");
    end
    if (sel == 0) iv0 = 1'b0;
    else          iv1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);
  endtask

  function automatic logic [63:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'h7FFF_FFFF;
      2:       return 64'h8000_0000;
      3:       return 64'hFFFF_FFFF;
      4:       return 64'h1;
      default: return {32'h0, $urandom};
    endcase
  endfunction

  // Monitors: pop on every handshake and require stability across stalled cycles.
  logic        hold0 = 1'b0, hold1 = 1'b0;
  logic [31:0] hs0;
  logic [2:0]  hf0, hf1;
  logic [0:0]  hs1;
  exp_t        e0, e1;

  always @(negedge clk) begin
    if (!rst_n) hold0 = 1'b0;
    else begin
      if (hold0) begin
        chk("hold_valid0", ov0, 1);
        chk("hold_s0", s0, hs0);
        chk("hold_flags0", f0, hf0);
      end
      if (ov0 && or0) begin
        if (q0.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_out0: got s=%0h expected no result", s0);
        end else begin
          e0 = q0.pop_front();
          chk("s0", s0, {31'b0, e0.s});
          chk("flags0", f0, e0.f);
        end
      end
      hold0 = ov0 && !or0;
      hs0 = s0;
      hf0 = f0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) hold1 = 1'b0;
    else begin
      if (hold1) begin
        chk("hold_valid1", ov1, 1);
        chk("hold_s1", s1, hs1);
        chk("hold_flags1", f1, hf1);
      end
      if (ov1 && or1) begin
        if (q1.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_out1: got s=%0h expected no result", s1);
        end else begin
          e1 = q1.pop_front();
          chk("s1", s1, e1.s);
          chk("flags1", f1, e1.f);
        end
      end
      hold1 = ov1 && !or1;
      hs1 = s1;
      hf1 = f1;
    end
  end

  logic [7:0] c8 [4];

  initial begin
    iv0 = 0; a0 = 0; b0 = 0; m0 = 0;
    iv1 = 0; a1 = 0; b1 = 0; m1 = 0;
    c8[0] = 8'h00; c8[1] = 8'h7F; c8[2] = 8'h80; c8[3] = 8'hFF;
    #1;
    chk("rst_out_valid", ov0, 0);
    chk("rst_in_ready", ir0, 1);
    chk("rst_s", s0, 0);
    chk("rst_flags", f0, 0);
    chk("rst_out_valid8", ov1, 0);
    chk("rst_in_ready8", ir1, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed overflow and 2-cycle latency
    want0 = 1'b1;
    send(0, 3'b010, 64'h8000_0000, 64'h1);
    chk("lat_not_early", ov0, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", ov0, 1);
    chk("ovf_s", s0, 1);
    chk("ovf_flags", f0, 3'b100);
    drain();

    // LTU vs LT back-to-back
    @(posedge clk);
    #1;
    send(0, 3'b011, 64'hFFFF_FFFF, 64'h1);
    send(0, 3'b010, 64'hFFFF_FFFF, 64'h1);
    chk("b2b_first_valid", ov0, 1);
    chk("b2b_ltu_s", s0, 0);
    @(posedge clk);
    #1;
    chk("b2b_second_valid", ov0, 1);
    chk("b2b_lt_s", s0, 1);
    drain();

    // Zero-compare modes ignore b
    @(posedge clk);
    #1;
    send(0, 3'b110, 64'h0, 64'h1234);
    send(0, 3'b111, 64'h0, 64'h1234);
    send(0, 3'b100, 64'h0, 64'h1234);
    send(0, 3'b101, 64'h0, 64'h1234);
    drain();

    // Backpressure: only two beats fit while out_ready is low
    @(posedge clk);
    #1;
    want0 = 1'b0;
    fork
      begin
        send(0, 3'b001, 64'h5, 64'h5);
        send(0, 3'b000, 64'h5, 64'h5);
        send(0, 3'b010, 64'h3, 64'hFFFF_FFFF);
        send(0, 3'b111, 64'h7, 64'h0);
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepts", q0.size(), 2);
        chk("bp_in_ready", ir0, 0);
        chk("bp_out_valid", ov0, 1);
        @(posedge clk);
        #1;
        want0 = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    @(posedge clk);
    #1;
    want0 = 1'b0;
    send(0, 3'b001, 64'h9, 64'h9);
    send(0, 3'b011, 64'h1, 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov0, 0);
    chk("midrst_s", s0, 0);
    chk("midrst_flags", f0, 0);
    chk("midrst_in_ready", ir0, 1);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    want0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_no_stale", ov0, 0);

    // Random traffic with random backpressure
    rand_rdy0 = 1'b1;
    repeat (300) begin
      send(0, 3'($urandom_range(0, 7)), pick32(), pick32());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_rdy0 = 1'b0;
    want0 = 1'b1;
    drain();

    // 8-bit sweep: every mode over corner pairs, then random operands
    rand_rdy1 = 1'b1;
    for (int m = 0; m < 8; m++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          send(1, 3'(m), {56'h0, c8[i]}, {56'h0, c8[j]});
    repeat (200)
      send(1, 3'($urandom_range(0, 7)), {56'h0, 8'($urandom)}, {56'h0, 8'($urandom)});
    rand_rdy1 = 1'b0;
    want1 = 1'b1;
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("final_idle0", ov0, 0);
    chk("final_idle1", ov1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmp_pipe.md
CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width (legal range 2..64).
REQ-002 The block SHALL have parameter OUT_W, default 32, giving the result width (>=1).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B; ignored by zero-compare modes.
REQ-009 mode  input  3  compare select, ALUFun[3:1] encoding.
REQ-010 out_valid  output  1  result beat available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 s  output  OUT_W  result: bit 0 = compare outcome, bits OUT_W-1:1 = 0.
REQ-013 flags  output  3  {ovf, neg, zero} of the subtraction that produced s.

Function
REQ-014 Mode encodings SHALL be: 001 EQ (a==b); 000 NEQ (a!=b); 010 LT signed (a<b); 011 LTU unsigned (a<b); 110 LEZ (a<=0); 101 LTZ (a<0); 111 GTZ (a>0); 100 GEZ (a>=0).
REQ-015 Every mode SHALL produce a defined result; no mode holds the previous s.
REQ-016 Stage 1 SHALL compute d = a - b' (WIDTH bits, two's complement), where b' = b for EQ/NEQ/LT/LTU and b' = 0 for the four zero-compare modes.
REQ-017 Stage 1 SHALL register zero = (d==0), neg = d[WIDTH-1], ovf = (a[W-1]!=b'[W-1]) && (d[W-1]!=a[W-1]), borrow = unsigned a < b', and mode.
REQ-018 Stage 2 SHALL evaluate: EQ zero; NEQ !zero; LT neg^ovf; LTU borrow; LEZ neg|zero; LTZ neg; GTZ !neg&!zero; GEZ !neg; register it into s[0], and register flags.
REQ-019 Stage 1 SHALL capture a beat when in_valid && in_ready.
REQ-020 Stage 1 SHALL advance into stage 2 when stage 1 is valid and (stage 2 is empty or out_ready is high).
REQ-021 in_ready SHALL equal !v1 || (!v2 || out_ready), combinationally, with no dependence on in_valid.
REQ-022 out_valid SHALL equal v2.
REQ-023 A result SHALL leave when out_valid && out_ready.
REQ-024 Latency from accepted input to out_valid SHALL be exactly 2 cycles when unstalled.
REQ-025 Throughput SHALL be one beat per cycle while out_ready stays high.
REQ-026 While out_valid && !out_ready, s and flags SHALL hold stable.
REQ-027 While stalled, at most 2 beats SHALL be buffered, one per stage.
REQ-028 No beat SHALL be dropped, duplicated or reordered.
REQ-029 A simultaneous drain of stage 2 and refill from stage 1 in the same cycle SHALL be lossless.
REQ-030 Stage 1 SHALL hold its beat when stage 2 is full and out_ready is low; in_ready SHALL then be low.
REQ-031 Beats offered while in_ready is low SHALL be ignored; the source must hold them.
REQ-032 WIDTH boundaries SHALL be exact: the most-negative operand and all-ones operand follow the two's-complement and unsigned rules above.

Reset
REQ-033 rst_n low SHALL asynchronously clear v1, v2, s, flags and all stage registers to 0.
REQ-034 After reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-035 Assertion of rst_n mid-operation SHALL discard in-flight beats; no result for them SHALL appear after release.
REQ-036 Deassertion of rst_n is synchronised externally; the first capture may occur on the first rising edge after release.

Verification
REQ-037 Signed overflow: WIDTH=32, mode LT, a=0x80000000, b=0x00000001, out_ready=1 -> 2 cycles later s=1, flags={1,0,0}.
REQ-038 Unsigned vs signed: a=0xFFFFFFFF, b=0x00000001. LTU -> s=0; LT -> s=1. Sent back-to-back: results on consecutive cycles, in order.
REQ-039 Zero-compare ignores b: a=0, b=0x1234. LEZ -> s=1; GTZ -> s=0; GEZ -> s=1; LTZ -> s=0.
REQ-040 Backpressure: 4 beats EQ/NEQ/LT/GTZ sent with out_ready held 0 -> in_ready falls after 2 accepts and out_valid holds the first result stable; release out_ready -> all 4 results delivered in order, none lost.
REQ-041 Reset mid-flight: 2 beats accepted, rst_n pulsed low before either exits -> out_valid=0 and s=0 immediately; no stale result after release.
REQ-042 Parameter sweep: WIDTH=8, OUT_W=1, all 8 modes over random and corner operands (0x00, 0x7F, 0x80, 0xFF) -> s matches a reference model on every beat.
